div16: RTL and testbench

DIV16 -- requirements
Module: div16

---
 rtl/fft_pkg.sv | 20 ++
 rtl/tc2mag.sv | 17 +
 rtl/div16.sv | 153 +++++++++++++++
 tb/tb_div16.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared defaults and state encoding for the div16 fixed-point divider.
`default_nettype none

package fft_pkg;

  localparam int DW_DEFAULT   = 17;
  localparam int CW_DEFAULT   = 8;
  localparam int FRAC_DEFAULT = 6;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MAG  = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } div16_state_t;

endpackage

`default_nettype wire

// File: rtl/tc2mag.sv
// Two's-complement to full-width unsigned magnitude; the most negative code maps exactly.
`default_nettype none

module tc2mag #(
  parameter int W = 8
) (
  input  logic [W-1:0] val,
  output logic [W-1:0] mag,
  output logic         neg
);

  assign neg = val[W-1];
  assign mag = neg ? -val : val;

endmodule

`default_nettype wire

// File: rtl/div16.sv
// Signed fixed-point divider q = (a << FRAC) / b, restoring, one quotient bit per cycle.
// Define DIV16_ROUND_EN for round-half-away-from-zero via one extra guard bit.
`default_nettype none

module div16
  import fft_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int CW   = CW_DEFAULT,
  parameter int FRAC = FRAC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_17bit,
  input  logic [CW-1:0] in_8bit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out,
  output logic          ovf,
  output logic          div_zero
);

`ifdef DIV16_ROUND_EN
  localparam int SH = FRAC + 1;
`else
  localparam int SH = FRAC;
`endif
  localparam int QW   = DW + FRAC;
  localparam int NB   = DW + SH;
  localparam int CNTW = $clog2(NB + 1);
  localparam logic [DW-1:0] MAXP = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] MINN = {1'b1, {(DW-1){1'b0}}};

  div16_state_t state, state_nxt;

  logic [DW-1:0]   a_reg;
  logic [CW-1:0]   b_reg;
  logic [CW-1:0]   mag_b_r;
  logic [CW-1:0]   rem;
  logic [NB-1:0]   quo;
  logic [CNTW-1:0] cnt;
  logic            sign;
  logic            a_neg;
  logic            zwait;

  logic [DW-1:0] mag_a_w;
  logic [CW-1:0] mag_b_w;
  logic          a_neg_w;
  logic          b_neg_w;

  tc2mag #(.W(DW)) u_mag_a (.val(a_reg), .mag(mag_a_w), .neg(a_neg_w));
  tc2mag #(.W(CW)) u_mag_b (.val(b_reg), .mag(mag_b_w), .neg(b_neg_w));

  logic [CW:0]   trial;
  logic [CW-1:0] diff;
  logic          ge;
  logic [QW-1:0] qmag;
  logic [DW-1:0] qlow;
  logic          sat;

  assign trial = {rem, quo[NB-1]};
  assign ge    = trial >= {1'b0, mag_b_r};
  assign diff  = trial[CW-1:0] - mag_b_r;

`ifdef DIV16_ROUND_EN
  assign qmag = quo[NB-1:1] + {{(QW-1){1'b0}}, quo[0]};
`else
  assign qmag = quo;
`endif
  assign qlow = qmag[DW-1:0];
  assign sat  = qmag > {{FRAC{1'b0}}, MAXP};

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid) state_nxt = S_MAG;
      S_MAG:  state_nxt = (mag_b_w == '0) ? S_FIX : S_CALC;
      S_CALC: if (cnt == CNTW'(NB - 1)) state_nxt = S_FIX;
      // Divide-by-zero holds FIX one extra cycle for a fixed 3-cycle latency.
      S_FIX:  if (!(div_zero && !zwait)) state_nxt = S_DONE;
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      mag_b_r  <= '0;
      rem      <= '0;
      quo      <= '0;
      cnt      <= '0;
      sign     <= 1'b0;
      a_neg    <= 1'b0;
      zwait    <= 1'b0;
      out      <= '0;
      ovf      <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_reg <= in_17bit;
            b_reg <= in_8bit;
          end
        end
        S_MAG: begin
          quo      <= {mag_a_w, {SH{1'b0}}};
          mag_b_r  <= mag_b_w;
          sign     <= a_neg_w ^ b_neg_w;
          a_neg    <= a_neg_w;
          div_zero <= (mag_b_w == '0);
          rem      <= '0;
          cnt      <= '0;
          zwait    <= 1'b0;
        end
        S_CALC: begin
          rem <= ge ? diff : trial[CW-1:0];
          quo <= {quo[NB-2:0], ge};
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          zwait <= 1'b1;
          if (div_zero) begin
            out <= a_neg ? MINN : MAXP;
            ovf <= 1'b0;
          end else if (sat) begin
            out <= sign ? MINN : MAXP;
            ovf <= 1'b1;
          end else begin
            out <= sign ? -qlow : qlow;
            ovf <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_div16.sv
// Directed self-checking bench for div16 with hand-computed expected quotients.
`default_nettype none

module tb_div16;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] in_17bit;
  logic [7:0]  in_8bit;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] out;
  logic        ovf;
  logic        div_zero;

  int n_cmp = 0;
  int n_err = 0;

`ifdef DIV16_ROUND_EN
  localparam int LAT = 26;
`else
  localparam int LAT = 25;
`endif

  div16 dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_17bit(in_17bit), .in_8bit(in_8bit),
    .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .ovf(ovf), .div_zero(div_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called #1 after a rising edge with the DUT in IDLE.
  task automatic run_op(input string tag, input int a, input int b,
                        input logic [16:0] eo, input logic eov, input logic edz, input int elat);
    int lat;
    in_17bit = 17'(a);
    in_8bit  = 8'(b);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, "_lat"}, lat, elat);
    check({tag, "_out"}, out, eo);
    check({tag, "_ovf"}, ovf, eov);
    check({tag, "_dz"},  div_zero, edz);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check({tag, "_rdy"}, in_ready, 1);
  endtask

  initial begin
    logic [16:0] held;
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_17bit = '0; in_8bit = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out",       out, 0);
    check("rst_ovf",       ovf, 0);
    check("rst_dz",        div_zero, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op("p1000_64",   1000,   64, 17'd1000,  1'b0, 1'b0, LAT);
    run_op("n1000_64",  -1000,   64, 17'h1FC18, 1'b0, 1'b0, LAT);
    run_op("p5_n2",         5,   -2, 17'h1FF60, 1'b0, 1'b0, LAT);
`ifdef DIV16_ROUND_EN
    run_op("p1_127",        1,  127, 17'd1,     1'b0, 1'b0, LAT);
    run_op("p1_n128",       1, -128, 17'h1FFFF, 1'b0, 1'b0, LAT);
    run_op("n7_5",         -7,    5, 17'h1FFA6, 1'b0, 1'b0, LAT);
`else
    run_op("p1_127",        1,  127, 17'd0,     1'b0, 1'b0, LAT);
    run_op("p1_n128",       1, -128, 17'd0,     1'b0, 1'b0, LAT);
    run_op("n7_5",         -7,    5, 17'h1FFA7, 1'b0, 1'b0, LAT);
`endif
    run_op("p2_n128",       2, -128, 17'h1FFFF, 1'b0, 1'b0, LAT);
    run_op("p100_3",      100,    3, 17'd2133,  1'b0, 1'b0, LAT);
    run_op("p65535_1",  65535,    1, 17'h0FFFF, 1'b1, 1'b0, LAT);
    run_op("n65536_n1",-65536,   -1, 17'h0FFFF, 1'b1, 1'b0, LAT);
    run_op("p1023_1",    1023,    1, 17'd65472, 1'b0, 1'b0, LAT);
    run_op("p1024_1",    1024,    1, 17'h0FFFF, 1'b1, 1'b0, LAT);
    run_op("n1024_1",   -1024,    1, 17'h10000, 1'b1, 1'b0, LAT);
    run_op("n5_z",         -5,    0, 17'h10000, 1'b0, 1'b1, 3);
    run_op("p5_z",          5,    0, 17'h0FFFF, 1'b0, 1'b1, 3);
    run_op("z_n3",          0,   -3, 17'd0,     1'b0, 1'b0, LAT);

    // Back-pressure: result must hold while out_ready stays low.
    in_17bit = 17'd300; in_8bit = 8'd64; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    seen = 0;
    while (!out_valid && seen < 100) begin
      @(posedge clk);
      #1 seen++;
    end
    check("stall_lat", seen, LAT);
    held = out;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("stall_out", out, held);
      check("stall_valid", out_valid, 1);
      check("stall_rdy", in_ready, 0);
    end
    check("stall_val", held, 17'd300);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    check("stall_done", in_ready, 1);

    // Reset in the middle of CALC abandons the operation.
    in_17bit = 17'd1000; in_8bit = 8'd64; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_rdy", in_ready, 1);
    check("mid_rst_out", out, 0);
    seen = 0;
    repeat (30) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1;
    end
    check("mid_rst_nopulse", seen, 0);

    run_op("after_rst", -1000, 64, 17'h1FC18, 1'b0, 1'b0, LAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
